sn7400_test_seq: RTL and testbench
==================================

SN7400_TEST_SEQ -- requirements
Module: sn7400_test_seq

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, range 1..15: cycles DUT outputs settle before sampling.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-005 The block SHALL have ports p1, p2, p4, p5, p9, p10, p12, p13  output  1 each  drive the gate inputs of the sn7400 device under test.
REQ-006 The block SHALL have ports p3, p6, p8, p11  input  1 each  gate outputs sampled from the device under test.
REQ-007 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-009 The block SHALL have port pass  output  1  high when the last completed run had zero errors.
REQ-010 The block SHALL have port test_count  output  5  test cases executed in the current or last run.
REQ-011 The block SHALL have port error_count  output  5  mismatching test cases in the current or last run.
REQ-012 The block SHALL have port fail_mask  output  4  bit g set when gate g had at least one mismatch.

Function
REQ-013 Gate map SHALL be: g0 a=p1 b=p2 y=p3; g1 a=p4 b=p5 y=p6; g2 a=p9 b=p10 y=p8; g3 a=p13 b=p12 y=p11.
REQ-014 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-015 In IDLE with start=1, the block SHALL clear test_count, error_count, fail_mask and pass, set gate index g=0 and vector v=0, and go to DRIVE.
REQ-016 In DRIVE (1 cycle), the block SHALL set gate g inputs a=v[1], b=v[0]; all other gate inputs SHALL be 0; then go to SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles with inputs held; then go to CHECK.
REQ-018 In CHECK (1 cycle), the block SHALL compare y of gate g against ~(a&b); any y not exactly equal (including X or Z in simulation) SHALL count as a mismatch.
REQ-019 In CHECK, test_count SHALL increment by 1; on mismatch, error_count SHALL increment by 1 and fail_mask[g] SHALL be set.
REQ-020 After CHECK, if v<3 the block SHALL set v=v+1, else v=0 and g=g+1; the next state SHALL be DRIVE, or DONE if g=3 and v=3.
REQ-021 Tests SHALL execute gate-sequentially (g0..g3) with v ascending 0..3 inside each gate, for 16 test cases total.
REQ-022 In DONE (1 cycle), done SHALL be 1, pass SHALL be set to (error_count==0), all p-outputs SHALL be 0, and the next state SHALL be IDLE.
REQ-023 Latency: with start sampled at edge k, done SHALL be high during the cycle following edge k+16*(SETTLE_CYC+2)+1.
REQ-024 start while busy SHALL be ignored; start asserted in the DONE cycle SHALL be ignored.
REQ-025 Results (test_count, error_count, fail_mask, pass) SHALL hold in IDLE until the next accepted start.
REQ-026 Counters SHALL NOT wrap; 16 is the maximum for both counts.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, all p-outputs 0, busy=0, done=0, pass=0, test_count=0, error_count=0, fail_mask=0, g=0, v=0.
REQ-028 rst asserted mid-run SHALL abort the run with no done pulse; a new start after rst deasserts SHALL perform a full 16-case run.

Verification
REQ-029 Correct sn7400 model, SETTLE_CYC=2, start pulse -> busy for 65 cycles, done once, pass=1, test_count=16, error_count=0, fail_mask=0000.
REQ-030 p8 stuck at 1 -> only g2 v=3 fails: error_count=1, fail_mask=0100, pass=0.
REQ-031 p3 left floating (Z) -> all 4 g0 cases fail: error_count=4, fail_mask=0001, pass=0.
REQ-032 rst pulsed 20 cycles after start -> all outputs zero immediately, no done; a following start yields test_count=16 and correct results.
REQ-033 start held high for an entire run, SETTLE_CYC=1 -> done 49 cycles after accept; start during busy and in DONE ignored; next run begins from IDLE.
REQ-034 During every DRIVE/SETTLE/CHECK cycle -> only the active gate's inputs nonzero, and they match (v[1], v[0]).

Source files
------------

// File: rtl/sn7400_test_seq.sv
// Sequenced functional tester for a quad 2-input NAND (sn7400): walks each gate
// through all four input vectors, lets outputs settle, and tallies mismatches.
module sn7400_test_seq #(
   parameter int SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       p1,
   output logic       p2,
   output logic       p4,
   output logic       p5,
   output logic       p9,
   output logic       p10,
   output logic       p12,
   output logic       p13,
   input  logic       p3,
   input  logic       p6,
   input  logic       p8,
   input  logic       p11,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] test_count,
   output logic [4:0] error_count,
   output logic [3:0] fail_mask
);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

   state_t     state_q;
   logic       start_q;
   logic [1:0] gate_q, vec_q;
   logic [3:0] scnt_q;
   logic [3:0] a_q, b_q;
   logic       busy_q, done_q, pass_q;
   logic [4:0] tcnt_q, ecnt_q;
   logic [3:0] fmask_q;

   logic [3:0] y;
   logic       y_sel, mism, last;
   logic [1:0] gate_d, vec_d;
   logic [4:0] tcnt_d, ecnt_d;

   // Case-equality so an undriven or unknown gate output is a mismatch in simulation.
   always_comb begin
      y      = {p11, p8, p6, p3};
      y_sel  = y[gate_q];
      mism   = (y_sel !== ~(a_q[gate_q] & b_q[gate_q]));
      last   = (gate_q == 2'd3) && (vec_q == 2'd3);
      vec_d  = vec_q + 2'd1;
      gate_d = (vec_q == 2'd3) ? gate_q + 2'd1 : gate_q;
      tcnt_d = (tcnt_q < 5'd16) ? tcnt_q + 5'd1 : tcnt_q;
      ecnt_d = (mism && ecnt_q < 5'd16) ? ecnt_q + 5'd1 : ecnt_q;
   end

   // start is registered in IDLE, so a run begins one edge after start is sampled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         gate_q  <= '0;
         vec_q   <= '0;
         scnt_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         tcnt_q  <= '0;
         ecnt_q  <= '0;
         fmask_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_q) begin
                  state_q <= DRIVE;
                  start_q <= 1'b0;
                  busy_q  <= 1'b1;
                  gate_q  <= '0;
                  vec_q   <= '0;
                  a_q     <= '0;
                  b_q     <= '0;
                  pass_q  <= 1'b0;
                  tcnt_q  <= '0;
                  ecnt_q  <= '0;
                  fmask_q <= '0;
               end else begin
                  start_q <= start;
               end
            end
            DRIVE: begin
               state_q <= SETTLE;
               scnt_q  <= 4'(SETTLE_CYC - 1);
            end
            SETTLE: begin
               if (scnt_q == 4'd0) state_q <= CHECK;
               else                scnt_q  <= scnt_q - 4'd1;
            end
            CHECK: begin
               tcnt_q <= tcnt_d;
               ecnt_q <= ecnt_d;
               if (mism) fmask_q[gate_q] <= 1'b1;
               if (last) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  pass_q  <= (ecnt_d == 5'd0);
                  gate_q  <= '0;
                  vec_q   <= '0;
                  a_q     <= '0;
                  b_q     <= '0;
               end else begin
                  state_q <= DRIVE;
                  gate_q  <= gate_d;
                  vec_q   <= vec_d;
                  for (int i = 0; i < 4; i++) begin
                     a_q[i] <= (gate_d == 2'(i)) & vec_d[1];
                     b_q[i] <= (gate_d == 2'(i)) & vec_d[0];
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               start_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign p1          = a_q[0];
   assign p2          = b_q[0];
   assign p4          = a_q[1];
   assign p5          = b_q[1];
   assign p9          = a_q[2];
   assign p10         = b_q[2];
   assign p13         = a_q[3];
   assign p12         = b_q[3];
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign test_count  = tcnt_q;
   assign error_count = ecnt_q;
   assign fail_mask   = fmask_q;

endmodule

// File: tb/tb_sn7400_test_seq.sv
// Bench for sn7400_test_seq: a faultable NAND model on the pins, a run-level
// reference model for counts/mask/pass, and per-cycle pin sequence checks.
module tb_sn7400_test_seq;

   localparam int S   = 2;
   localparam int RUN = 16 * (S + 2) + 1;

   logic clk = 1'b0;
   logic rst, start;
   logic p1, p2, p4, p5, p9, p10, p12, p13;
   logic p3, p6, p8, p11;
   logic busy, done, pass;
   logic [4:0] test_count, error_count;
   logic [3:0] fail_mask;

   // per-gate fault: 0 good, 1 stuck-0, 2 stuck-1, 3 floating, 4 inverted
   int   fault [4];
   logic zval;
   int   n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   sn7400_test_seq #(.SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .start(start),
      .p1(p1), .p2(p2), .p4(p4), .p5(p5), .p9(p9), .p10(p10), .p12(p12), .p13(p13),
      .p3(p3), .p6(p6), .p8(p8), .p11(p11),
      .busy(busy), .done(done), .pass(pass),
      .test_count(test_count), .error_count(error_count), .fail_mask(fail_mask)
   );

   function automatic logic inj(input int mode, input logic y, input logic z);
      case (mode)
         0:       return y;
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return z;
         default: return ~y;
      endcase
   endfunction

   always_comb begin
      p3  = inj(fault[0], ~(p1 & p2), zval);
      p6  = inj(fault[1], ~(p4 & p5), zval);
      p8  = inj(fault[2], ~(p9 & p10), zval);
      p11 = inj(fault[3], ~(p13 & p12), zval);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected outcome of one full run with the current fault setting.
   task automatic model(output int err, output int mask);
      logic a, b, e, o;
      err = 0; mask = 0;
      for (int g = 0; g < 4; g++)
         for (int v = 0; v < 4; v++) begin
            a = v[1]; b = v[0];
            e = ~(a & b);
            o = inj(fault[g], e, zval);
            if (o !== e) begin
               err++;
               mask |= (1 << g);
            end
         end
   endtask

   function automatic logic [7:0] exp_pins(input int g, input int v);
      logic [3:0] a, b;
      a = '0; b = '0;
      a[g] = v[1];
      b[g] = v[0];
      return {a, b};
   endfunction

   function automatic logic [7:0] dut_pins();
      return {p13, p9, p4, p1, p12, p10, p5, p2};
   endfunction

   task automatic run_and_check(input string tag, input bit hold);
      int err, mask, busy_cyc, done_cyc, done_cnt, bad_pins, idx;
      logic [7:0] ep;
      model(err, mask);
      busy_cyc = 0; done_cyc = 0; done_cnt = 0; bad_pins = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 if (!hold) start = 1'b0;
      for (int n = 1; n <= RUN + 1; n++) begin
         @(posedge clk); #1;
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = n;
         end
         if (n < RUN) begin
            idx = (n - 1) / (S + 2);
            ep  = exp_pins(idx / 4, idx % 4);
         end else begin
            ep = '0;
         end
         if (dut_pins() !== ep) bad_pins++;
      end
      chk({tag, "_latency"}, done_cyc, RUN);
      chk({tag, "_busy_cycles"}, busy_cyc, RUN);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_pin_seq_errs"}, bad_pins, 0);
      chk({tag, "_test_count"}, test_count, 16);
      chk({tag, "_error_count"}, error_count, err);
      chk({tag, "_fail_mask"}, fail_mask, mask);
      chk({tag, "_pass"}, pass, (err == 0));
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 4 * RUN; i++) begin
         @(posedge clk); #1;
         if (done) break;
      end
      chk(tag, done, 1);
   endtask

   task automatic set_faults(input int f0, input int f1, input int f2, input int f3);
      fault[0] = f0; fault[1] = f1; fault[2] = f2; fault[3] = f3;
   endtask

   initial begin
      int seen, hold_ec, gap;
      zval  = 1'bz;
      rst   = 1'b1;
      start = 1'b0;
      set_faults(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pins", dut_pins(), 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_counts", {test_count, error_count, fail_mask}, 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);

      run_and_check("clean", 1'b0);
      hold_ec = int'(error_count);
      repeat (7) @(posedge clk);
      #1;
      chk("hold_test_count", test_count, 16);
      chk("hold_error_count", error_count, hold_ec);
      chk("hold_pass", pass, 1);

      set_faults(0, 0, 2, 0);
      run_and_check("p8_stuck1", 1'b0);
      chk("p8_stuck1_mask", fail_mask, 4'b0100);

      set_faults(3, 0, 0, 0);
      run_and_check("p3_float", 1'b0);

      // Abort mid-run with reset.
      set_faults(0, 0, 0, 0);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_pins", dut_pins(), 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_results", {pass, test_count, error_count, fail_mask}, 0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 2 * RUN; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("abort_no_activity", seen, 0);
      run_and_check("after_abort", 1'b0);

      // start held for a whole run: DONE-cycle start ignored, rerun goes via IDLE.
      set_faults(0, 4, 0, 0);
      run_and_check("held_start", 1'b1);
      @(posedge clk); #1;
      chk("held_idle_gap", busy, 0);
      @(posedge clk); #1;
      chk("held_restart_busy", busy, 1);
      chk("held_restart_cleared", test_count, 0);
      start = 1'b0;
      wait_done("held_rerun_done");
      chk("held_rerun_count", error_count, 4);
      @(posedge clk);

      for (int r = 0; r < 6; r++) begin
         for (int g = 0; g < 4; g++)
            fault[g] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         gap = int'($urandom_range(0, 5));
         repeat (gap) @(posedge clk);
         run_and_check($sformatf("rand%0d", r), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
